// File: rtl/checker_result_stats_if.sv
// Bus between the trace-checker statistics block and its driver/host side.
// The master drives checker outputs plus clear/select; the slave returns stats and the snapshot.
interface checker_result_stats_if #(
    parameter int CNT_W = 16,
    parameter int IDX_W = 16
);
    logic [1:0]       format_type;
    logic [3:0]       error_code;
    logic             clear;
    logic [2:0]       rd_sel;
    logic [CNT_W-1:0] rd_data;
    logic             first_err_valid;
    logic [3:0]       first_err_code;
    logic [1:0]       first_err_type;
    logic [IDX_W-1:0] first_err_index;
    logic             illegal_seen;

    modport master (
        output format_type, error_code, clear, rd_sel,
        input  rd_data, first_err_valid, first_err_code, first_err_type,
               first_err_index, illegal_seen
    );

    modport slave (
        input  format_type, error_code, clear, rd_sel,
        output rd_data, first_err_valid, first_err_code, first_err_type,
               first_err_index, illegal_seen
    );
endinterface

// File: rtl/checker_result_stats.sv
// Saturating record statistics and first-error snapshot for the trace-string checker.
// A record is the rising edge of format_type!=0; counters are read through a registered mux.

module checker_result_stats_satcnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clear,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);
    localparam logic [W-1:0] MAX = '1;

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (i_clear)
            r_cnt <= '0;
        else if (i_inc && (r_cnt != MAX))
            r_cnt <= r_cnt + W'(1);
    end

    assign o_cnt = r_cnt;
endmodule

module checker_result_stats #(
    parameter int CNT_W = 16,
    parameter int IDX_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    checker_result_stats_if.slave  bus
);
    localparam int NCNT = 8;

    logic                        w_active;
    logic                        w_rec;
    logic                        w_err;
    logic [NCNT-1:0]             w_inc;
    logic [IDX_W-1:0]            w_idx;
    logic [NCNT-1:0][CNT_W-1:0]  w_cnt;

    logic                        r_prev_active;
    logic [CNT_W-1:0]            r_rd_data;
    logic                        r_first_valid;
    logic [3:0]                  r_first_code;
    logic [1:0]                  r_first_type;
    logic [IDX_W-1:0]            r_first_index;
    logic                        r_illegal_seen;

    assign w_active = (bus.format_type != 2'd0);
    assign w_rec    = w_active & ~r_prev_active;
    assign w_err    = (bus.error_code != 4'd0);

    // Counter map: 0 total, 1 reg, 2 mem, 3 errored, 4..7 one per error bit.
    always_comb begin
        w_inc      = '0;
        w_inc[0]   = w_rec;
        w_inc[1]   = w_rec && (bus.format_type == 2'd1);
        w_inc[2]   = w_rec && (bus.format_type == 2'd2);
        w_inc[3]   = w_rec && w_err;
        w_inc[7:4] = {4{w_rec}} & bus.error_code;
    end

    for (genvar g = 0; g < NCNT; g++) begin : g_cnt
        checker_result_stats_satcnt #(.W(CNT_W)) u_cnt (
            .clk     (clk),
            .reset   (reset),
            .i_clear (bus.clear),
            .i_inc   (w_inc[g]),
            .o_cnt   (w_cnt[g])
        );
    end

    // Snapshot index is the pre-increment total, clamped when the index field is narrower.
    if (IDX_W >= CNT_W) begin : g_idx_wide
        assign w_idx = IDX_W'(w_cnt[0]);
    end else begin : g_idx_narrow
        localparam logic [CNT_W-1:0] IDX_MAX = CNT_W'({IDX_W{1'b1}});
        assign w_idx = (w_cnt[0] > IDX_MAX) ? '1 : w_cnt[0][IDX_W-1:0];
    end

    // prev_active tracks the input even during clear so a held record is not recounted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_prev_active <= 1'b0;
        else
            r_prev_active <= w_active;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_data      <= '0;
            r_first_valid  <= 1'b0;
            r_first_code   <= 4'd0;
            r_first_type   <= 2'd0;
            r_first_index  <= '0;
            r_illegal_seen <= 1'b0;
        end else if (bus.clear) begin
            r_rd_data      <= '0;
            r_first_valid  <= 1'b0;
            r_first_code   <= 4'd0;
            r_first_type   <= 2'd0;
            r_first_index  <= '0;
            r_illegal_seen <= 1'b0;
        end else begin
            r_rd_data <= w_cnt[bus.rd_sel];
            if (w_rec && (bus.format_type == 2'd3))
                r_illegal_seen <= 1'b1;
            if (w_rec && w_err && !r_first_valid) begin
                r_first_valid <= 1'b1;
                r_first_code  <= bus.error_code;
                r_first_type  <= bus.format_type;
                r_first_index <= w_idx;
            end
        end
    end

    assign bus.rd_data         = r_rd_data;
    assign bus.first_err_valid = r_first_valid;
    assign bus.first_err_code  = r_first_code;
    assign bus.first_err_type  = r_first_type;
    assign bus.first_err_index = r_first_index;
    assign bus.illegal_seen    = r_illegal_seen;
endmodule

// File: tb/tb_checker_result_stats.sv
// Directed bench for checker_result_stats: a 16-bit instance for function and a
// 4-bit-counter / 3-bit-index instance for saturation.
module tb_checker_result_stats;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    checker_result_stats_if #(.CNT_W(16), .IDX_W(16)) bus ();
    checker_result_stats_if #(.CNT_W(4),  .IDX_W(3))  sbus ();

    checker_result_stats #(.CNT_W(16), .IDX_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    checker_result_stats #(.CNT_W(4), .IDX_W(3)) dut_small (
        .clk   (clk),
        .reset (reset),
        .bus   (sbus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rd(input logic [2:0] sel, output logic [15:0] v);
        bus.rd_sel = sel;
        tick();
        v = bus.rd_data;
    endtask

    task automatic srd(input logic [2:0] sel, output logic [3:0] v);
        sbus.rd_sel = sel;
        tick();
        v = sbus.rd_data;
    endtask

    task automatic send(input logic [1:0] ft, input logic [3:0] ec, input int hold);
        bus.format_type = ft;
        bus.error_code  = ec;
        repeat (hold) tick();
        bus.format_type = 2'd0;
        bus.error_code  = 4'd0;
        tick();
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] v;
        reset = 1'b1;
        bus.format_type = 2'd0; bus.error_code = 4'd0; bus.clear = 1'b0; bus.rd_sel = 3'd0;
        sbus.format_type = 2'd0; sbus.error_code = 4'd0; sbus.clear = 1'b0; sbus.rd_sel = 3'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int s = 0; s < 8; s++) begin
            rd(3'(s), v);
            n_vec++;
            if (v !== 16'd0) begin
                n_err++; $display("FAIL reset_cnt%0d: got %0d want 0", s, v);
            end
        end
        n_vec++;
        if (bus.first_err_valid !== 1'b0 || bus.illegal_seen !== 1'b0) begin
            n_err++; $display("FAIL reset_flags: valid=%b illegal=%b want 0 0",
                              bus.first_err_valid, bus.illegal_seen);
        end
    endtask

    task automatic test_single_record();
        logic [15:0] v;
        send(2'd1, 4'd0, 1);
        rd(3'd0, v); n_vec++;
        if (v !== 16'd1) begin n_err++; $display("FAIL t1_total: got %0d want 1", v); end
        rd(3'd1, v); n_vec++;
        if (v !== 16'd1) begin n_err++; $display("FAIL t1_reg: got %0d want 1", v); end
        rd(3'd3, v); n_vec++;
        if (v !== 16'd0) begin n_err++; $display("FAIL t1_errored: got %0d want 0", v); end
        n_vec++;
        if (bus.first_err_valid !== 1'b0) begin
            n_err++; $display("FAIL t1_valid: got %b want 0", bus.first_err_valid);
        end
    endtask

    task automatic test_held_record();
        logic [15:0] v;
        do_clear();
        send(2'd2, 4'b0101, 3);
        rd(3'd0, v); n_vec++;
        if (v !== 16'd1) begin n_err++; $display("FAIL t2_total: got %0d want 1", v); end
        rd(3'd2, v); n_vec++;
        if (v !== 16'd1) begin n_err++; $display("FAIL t2_mem: got %0d want 1", v); end
        rd(3'd1, v); n_vec++;
        if (v !== 16'd0) begin n_err++; $display("FAIL t2_reg: got %0d want 0", v); end
        rd(3'd3, v); n_vec++;
        if (v !== 16'd1) begin n_err++; $display("FAIL t2_errored: got %0d want 1", v); end
        rd(3'd4, v); n_vec++;
        if (v !== 16'd1) begin n_err++; $display("FAIL t2_time: got %0d want 1", v); end
        rd(3'd5, v); n_vec++;
        if (v !== 16'd0) begin n_err++; $display("FAIL t2_pc: got %0d want 0", v); end
        rd(3'd6, v); n_vec++;
        if (v !== 16'd1) begin n_err++; $display("FAIL t2_addr: got %0d want 1", v); end
        n_vec++;
        if (bus.first_err_valid !== 1'b1 || bus.first_err_code !== 4'b0101 ||
            bus.first_err_type !== 2'd2 || bus.first_err_index !== 16'd0) begin
            n_err++;
            $display("FAIL t2_snap: got v=%b c=%b t=%0d i=%0d want 1 0101 2 0",
                     bus.first_err_valid, bus.first_err_code, bus.first_err_type,
                     bus.first_err_index);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] v;
        logic [3:0]  errs [5];
        errs = '{4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0010};
        do_clear();
        for (int r = 0; r < 5; r++) send(2'd1, errs[r], 1);
        rd(3'd0, v); n_vec++;
        if (v !== 16'd5) begin n_err++; $display("FAIL t3_total: got %0d want 5", v); end
        rd(3'd1, v); n_vec++;
        if (v !== 16'd5) begin n_err++; $display("FAIL t3_reg: got %0d want 5", v); end
        rd(3'd3, v); n_vec++;
        if (v !== 16'd2) begin n_err++; $display("FAIL t3_errored: got %0d want 2", v); end
        rd(3'd7, v); n_vec++;
        if (v !== 16'd1) begin n_err++; $display("FAIL t3_grf: got %0d want 1", v); end
        rd(3'd5, v); n_vec++;
        if (v !== 16'd1) begin n_err++; $display("FAIL t3_pc: got %0d want 1", v); end
        rd(3'd4, v); n_vec++;
        if (v !== 16'd0) begin n_err++; $display("FAIL t3_time: got %0d want 0", v); end
        n_vec++;
        if (bus.first_err_code !== 4'b1000 || bus.first_err_type !== 2'd1 ||
            bus.first_err_index !== 16'd2) begin
            n_err++;
            $display("FAIL t3_snap: got c=%b t=%0d i=%0d want 1000 1 2",
                     bus.first_err_code, bus.first_err_type, bus.first_err_index);
        end
    endtask

    task automatic test_saturation();
        logic [3:0] v;
        for (int r = 0; r < 17; r++) begin
            sbus.format_type = 2'd1;
            sbus.error_code  = (r == 16) ? 4'b0001 : 4'b0000;
            tick();
            sbus.format_type = 2'd0;
            sbus.error_code  = 4'd0;
            tick();
        end
        srd(3'd0, v); n_vec++;
        if (v !== 4'd15) begin n_err++; $display("FAIL t4_total: got %0d want 15", v); end
        srd(3'd1, v); n_vec++;
        if (v !== 4'd15) begin n_err++; $display("FAIL t4_reg: got %0d want 15", v); end
        srd(3'd3, v); n_vec++;
        if (v !== 4'd1) begin n_err++; $display("FAIL t4_errored: got %0d want 1", v); end
        n_vec++;
        if (sbus.first_err_valid !== 1'b1 || sbus.first_err_index !== 3'd7) begin
            n_err++; $display("FAIL t4_index_sat: got v=%b i=%0d want 1 7",
                              sbus.first_err_valid, sbus.first_err_index);
        end
    endtask

    task automatic test_illegal_and_clear();
        logic [15:0] v;
        do_clear();
        send(2'd3, 4'd0, 1);
        rd(3'd0, v); n_vec++;
        if (v !== 16'd1) begin n_err++; $display("FAIL t5_total: got %0d want 1", v); end
        rd(3'd1, v); n_vec++;
        if (v !== 16'd0) begin n_err++; $display("FAIL t5_reg: got %0d want 0", v); end
        rd(3'd2, v); n_vec++;
        if (v !== 16'd0) begin n_err++; $display("FAIL t5_mem: got %0d want 0", v); end
        n_vec++;
        if (bus.illegal_seen !== 1'b1) begin
            n_err++; $display("FAIL t5_illegal: got %b want 1", bus.illegal_seen);
        end
        send(2'd1, 4'b0100, 1);
        rd(3'd0, v);
        do_clear();
        n_vec++;
        if (bus.rd_data !== 16'd0 || bus.illegal_seen !== 1'b0 || bus.first_err_valid !== 1'b0 ||
            bus.first_err_code !== 4'd0 || bus.first_err_type !== 2'd0 ||
            bus.first_err_index !== 16'd0) begin
            n_err++;
            $display("FAIL t5_clear_flags: got rd=%0d ill=%b v=%b c=%b t=%0d i=%0d want all 0",
                     bus.rd_data, bus.illegal_seen, bus.first_err_valid, bus.first_err_code,
                     bus.first_err_type, bus.first_err_index);
        end
        for (int s = 0; s < 8; s++) begin
            rd(3'(s), v);
            n_vec++;
            if (v !== 16'd0) begin
                n_err++; $display("FAIL t5_clear_cnt%0d: got %0d want 0", s, v);
            end
        end
    endtask

    task automatic test_clear_collision_and_async_reset();
        logic [15:0] v;
        bus.clear = 1'b1;
        bus.format_type = 2'd1;
        tick();
        bus.clear = 1'b0;
        tick();
        bus.format_type = 2'd0;
        tick();
        rd(3'd0, v); n_vec++;
        if (v !== 16'd0) begin n_err++; $display("FAIL t6_clear_drop: got %0d want 0", v); end

        send(2'd3, 4'b0010, 1);
        rd(3'd0, v); n_vec++;
        if (v !== 16'd1 || bus.illegal_seen !== 1'b1 || bus.first_err_valid !== 1'b1) begin
            n_err++; $display("FAIL t6_pre_reset: got rd=%0d ill=%b v=%b want 1 1 1",
                              v, bus.illegal_seen, bus.first_err_valid);
        end
        bus.format_type = 2'd1;
        #1 reset = 1'b1;
        #1;
        n_vec++;
        if (bus.rd_data !== 16'd0 || bus.illegal_seen !== 1'b0 || bus.first_err_valid !== 1'b0 ||
            bus.first_err_code !== 4'd0 || bus.first_err_type !== 2'd0) begin
            n_err++;
            $display("FAIL t6_async_reset: got rd=%0d ill=%b v=%b c=%b t=%0d want all 0",
                     bus.rd_data, bus.illegal_seen, bus.first_err_valid, bus.first_err_code,
                     bus.first_err_type);
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
        bus.format_type = 2'd0;
        tick();
        rd(3'd0, v); n_vec++;
        if (v !== 16'd1) begin n_err++; $display("FAIL t6_recount_after_reset: got %0d want 1", v); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_single_record();
        test_held_record();
        test_back_to_back();
        test_saturation();
        test_illegal_and_clear();
        test_clear_collision_and_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
